// File: rtl/kbsw_io_device.sv
// Memory-mapped KEY/SW responder: synchronizes and debounces both input buses and
// exposes data plus ready/overrun/ie control registers with an interrupt request.
module kbsw_io_device #(
  parameter int unsigned           DBITS           = 32,
  parameter logic [DBITS-1:0]      ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0]      ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0]      ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]      ADDR_SCTRL      = 32'hF0000114,
  parameter int unsigned           DEBOUNCE_CYCLES = 100000,
  parameter int unsigned           CNT_BITS        = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] abus,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  output logic             irq
);

  localparam int unsigned KBITS = 4;
  localparam int unsigned SBITS = 10;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [KBITS-1:0]    k_sync1, k_sync2, k_samp, k_deb;
  logic [SBITS-1:0]    s_sync1, s_sync2, s_samp, s_deb;
  logic [CNT_BITS-1:0] cnt;
  logic                tick;
  logic                k_chg, s_chg;
  logic                k_rdy, k_ovr, k_ie, s_rdy, s_ovr, s_ie;
  logic                k_rdy_n, k_ovr_n, k_ie_n, s_rdy_n, s_ovr_n, s_ie_n;
  logic                sel_kdata, sel_sdata, sel_kctrl, sel_sctrl;
  logic                k_rd_data, s_rd_data, k_wr_ctrl, s_wr_ctrl;
  logic                unused_wdata;

  assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3], wdata[1:0]};

  assign tick = (cnt == CNT_MAX);

  // A change event fires when a value stable across two ticks differs from deb.
  assign k_chg = tick && (k_sync2 == k_samp) && (k_sync2 != k_deb);
  assign s_chg = tick && (s_sync2 == s_samp) && (s_sync2 != s_deb);

  assign sel_kdata = (abus == ADDR_KDATA);
  assign sel_sdata = (abus == ADDR_SDATA);
  assign sel_kctrl = (abus == ADDR_KCTRL);
  assign sel_sctrl = (abus == ADDR_SCTRL);
  assign hit       = sel_kdata | sel_sdata | sel_kctrl | sel_sctrl;

  assign k_rd_data = re & sel_kdata;
  assign s_rd_data = re & sel_sdata;
  assign k_wr_ctrl = we & sel_kctrl;
  assign s_wr_ctrl = we & sel_sctrl;

  // Load data mux.
  always_comb begin
    rdata = '0;
    if (sel_kdata) begin
      rdata[KBITS-1:0] = k_deb;
    end else if (sel_sdata) begin
      rdata[SBITS-1:0] = s_deb;
    end else if (sel_kctrl) begin
      rdata[0] = k_rdy;
      rdata[2] = k_ovr;
      rdata[4] = k_ie;
    end else if (sel_sctrl) begin
      rdata[0] = s_rdy;
      rdata[2] = s_ovr;
      rdata[4] = s_ie;
    end
  end

  // Status next state: stores first, then event/read priority so overrun set wins.
  always_comb begin
    k_rdy_n = k_rdy;
    k_ovr_n = k_ovr;
    k_ie_n  = k_ie;
    s_rdy_n = s_rdy;
    s_ovr_n = s_ovr;
    s_ie_n  = s_ie;

    if (k_wr_ctrl) begin
      k_ie_n = wdata[4];
      if (!wdata[2]) k_ovr_n = 1'b0;
    end
    if (s_wr_ctrl) begin
      s_ie_n = wdata[4];
      if (!wdata[2]) s_ovr_n = 1'b0;
    end

    if (k_chg && k_rdy && !k_rd_data) k_ovr_n = 1'b1;
    else if (k_chg)                   k_rdy_n = 1'b1;
    else if (k_rd_data)               k_rdy_n = 1'b0;

    if (s_chg && s_rdy && !s_rd_data) s_ovr_n = 1'b1;
    else if (s_chg)                   s_rdy_n = 1'b1;
    else if (s_rd_data)               s_rdy_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_sync1 <= '0;
      k_sync2 <= '0;
      k_samp  <= '0;
      k_deb   <= '0;
      s_sync1 <= '0;
      s_sync2 <= '0;
      s_samp  <= '0;
      s_deb   <= '0;
      cnt     <= '0;
      k_rdy   <= 1'b0;
      k_ovr   <= 1'b0;
      k_ie    <= 1'b0;
      s_rdy   <= 1'b0;
      s_ovr   <= 1'b0;
      s_ie    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      // KEY is active-low on the board; invert so 1 means pressed.
      k_sync1 <= ~KEY;
      k_sync2 <= k_sync1;
      s_sync1 <= SW;
      s_sync2 <= s_sync1;
      cnt     <= tick ? '0 : cnt + CNT_BITS'(1);
      if (tick) begin
        k_samp <= k_sync2;
        s_samp <= s_sync2;
        if (k_sync2 == k_samp) k_deb <= k_sync2;
        if (s_sync2 == s_samp) s_deb <= s_sync2;
      end
      k_rdy <= k_rdy_n;
      k_ovr <= k_ovr_n;
      k_ie  <= k_ie_n;
      s_rdy <= s_rdy_n;
      s_ovr <= s_ovr_n;
      s_ie  <= s_ie_n;
      irq   <= (k_rdy_n & k_ie_n) | (s_rdy_n & s_ie_n);
    end
  end

endmodule

// File: tb/tb_kbsw_io_device.sv
// Directed plus randomized bench for kbsw_io_device against a cycle-level reference model.
module tb_kbsw_io_device;

  localparam int unsigned D = 4;
  localparam logic [31:0] A_KD   = 32'hF0000010;
  localparam logic [31:0] A_SD   = 32'hF0000014;
  localparam logic [31:0] A_KC   = 32'hF0000110;
  localparam logic [31:0] A_SC   = 32'hF0000114;
  localparam logic [31:0] A_NONE = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] abus, wdata, rdata;
  logic        we, re, hit, irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kbsw_io_device #(
    .DBITS(32), .ADDR_KDATA(A_KD), .ADDR_SDATA(A_SD), .ADDR_KCTRL(A_KC), .ADDR_SCTRL(A_SC),
    .DEBOUNCE_CYCLES(D), .CNT_BITS(3)
  ) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .abus(abus), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .hit(hit), .irq(irq)
  );

  // Reference model: edge count since reset, two-deep delay queues, rule-based status.
  int          m_cycles;
  logic [3:0]  mk_pipe[$];
  logic [9:0]  ms_pipe[$];
  logic [3:0]  mk_samp, mk_deb;
  logic [9:0]  ms_samp, ms_deb;
  bit          mk_rdy, mk_ovr, mk_ie, ms_rdy, ms_ovr, ms_ie, m_irq;

  task automatic model_reset();
    m_cycles = 0;
    mk_pipe = {};
    ms_pipe = {};
    repeat (2) begin
      mk_pipe.push_back(4'h0);
      ms_pipe.push_back(10'h0);
    end
    mk_samp = '0; mk_deb = '0; ms_samp = '0; ms_deb = '0;
    mk_rdy = 0; mk_ovr = 0; mk_ie = 0; ms_rdy = 0; ms_ovr = 0; ms_ie = 0; m_irq = 0;
  endtask

  task automatic upd(input bit ev, input bit rd, input bit wr, input logic [31:0] wd,
                     inout bit rdy, inout bit ovr, inout bit ie);
    if (wr) begin
      ie = wd[4];
      if (!wd[2]) ovr = 0;
    end
    if (ev && rdy && !rd) ovr = 1;
    else if (ev)          rdy = 1;
    else if (rd)          rdy = 0;
  endtask

  function automatic bit k_event_next();
    return ((m_cycles % D) == D - 1) && (mk_pipe[0] == mk_samp) && (mk_pipe[0] != mk_deb);
  endfunction

  task automatic model_edge();
    bit tick, kev, sev;
    logic [3:0] kin;
    logic [9:0] sin;
    if (reset) begin
      model_reset();
      return;
    end
    tick = (m_cycles % D) == D - 1;
    kin = mk_pipe.pop_front();
    mk_pipe.push_back(~KEY);
    sin = ms_pipe.pop_front();
    ms_pipe.push_back(SW);
    kev = tick && (kin == mk_samp) && (kin != mk_deb);
    sev = tick && (sin == ms_samp) && (sin != ms_deb);
    if (tick) begin
      if (kin == mk_samp) mk_deb = kin;
      if (sin == ms_samp) ms_deb = sin;
      mk_samp = kin;
      ms_samp = sin;
    end
    upd(kev, re && abus == A_KD, we && abus == A_KC, wdata, mk_rdy, mk_ovr, mk_ie);
    upd(sev, re && abus == A_SD, we && abus == A_SC, wdata, ms_rdy, ms_ovr, ms_ie);
    m_irq = (mk_rdy && mk_ie) || (ms_rdy && ms_ie);
    m_cycles++;
  endtask

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    case (a)
      A_KD:    return {28'b0, mk_deb};
      A_SD:    return {22'b0, ms_deb};
      A_KC:    return {27'b0, mk_ie, 1'b0, mk_ovr, 1'b0, mk_rdy};
      A_SC:    return {27'b0, ms_ie, 1'b0, ms_ovr, 1'b0, ms_rdy};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit exp_hit(input logic [31:0] a);
    return (a == A_KD) || (a == A_SD) || (a == A_KC) || (a == A_SC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance DUT and model together.
  task automatic cycle();
    #2;
    chk("rdata", rdata, exp_rdata(abus));
    chk("hit", 32'(hit), 32'(exp_hit(abus)));
    chk("irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    abus = a; re = 0; we = 0;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    abus = a; we = 1; re = 0; wdata = d;
    cycle();
    we = 0; wdata = 0;
  endtask

  task automatic load(input logic [31:0] a);
    abus = a; re = 1; we = 0;
    cycle();
    re = 0;
  endtask

  initial begin
    int n;
    bit found;
    reset = 1; KEY = 4'hF; SW = 10'h0; abus = 0; wdata = 0; we = 0; re = 0;
    @(posedge clk);
    model_reset();
    #1;
    cycle();
    reset = 0;

    // 1: reset state
    peek("rst_kdata", A_KD, 32'h0); chk("rst_hit_kd", 32'(hit), 32'h1);
    peek("rst_sdata", A_SD, 32'h0); chk("rst_hit_sd", 32'(hit), 32'h1);
    peek("rst_kctrl", A_KC, 32'h0); chk("rst_hit_kc", 32'(hit), 32'h1);
    peek("rst_sctrl", A_SC, 32'h0); chk("rst_hit_sc", 32'(hit), 32'h1);
    peek("unmapped_rdata", A_NONE, 32'h0); chk("unmapped_hit", 32'(hit), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    run(2);

    // 2: switch change detected, DATA read clears ready
    SW = 10'h2A5;
    run(12);
    peek("sw_data", A_SD, 32'h2A5);
    peek("sw_ready", A_SC, 32'h1);
    load(A_SD);
    peek("sw_ready_clr", A_SC, 32'h0);

    // 3: short key glitch rejected, long press accepted
    KEY = 4'hD; run(2);
    KEY = 4'hF; run(12);
    peek("glitch_kdata", A_KD, 32'h0);
    peek("glitch_kctrl", A_KC, 32'h0);
    KEY = 4'hD; run(12);
    peek("key1_kdata", A_KD, 32'h2);

    // 4: overrun and write-0-to-clear
    SW = 10'h001; run(12);
    SW = 10'h003; run(12);
    peek("ovr_set", A_SC, 32'h5);
    store(A_SC, 32'h0);
    peek("ovr_clr", A_SC, 32'h1);
    store(A_SC, 32'h4);
    peek("ovr_keep", A_SC, 32'h1);

    // 5: interrupt timing and event/read collision
    load(A_KD);
    store(A_KC, 32'h10);
    KEY = 4'hC;
    abus = A_KC;
    n = 0;
    while (!mk_rdy && n < 20) begin cycle(); n++; end
    chk("irq_ready_bound", 32'(n < 20), 32'h1);
    #2;
    chk("irq_with_ready", 32'(irq), 32'h1);
    chk("ready_bit", rdata, 32'h11);
    load(A_KD);
    #1;
    chk("irq_after_read", 32'(irq), 32'h0);
    KEY = 4'hF;
    abus = A_KC;
    n = 0;
    while (!mk_rdy && n < 20) begin cycle(); n++; end
    chk("release_ready_bound", 32'(n < 20), 32'h1);
    KEY = 4'hE;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (k_event_next()) begin
        found = 1;
        load(A_KD);
      end else begin
        abus = A_KC;
        cycle();
      end
    end
    chk("collide_found", 32'(found), 32'h1);
    peek("collide_kctrl", A_KC, 32'h11);
    run(1);

    // 6: reset mid-debounce, then full latency for the held value
    SW = 10'h155;
    run(4);
    reset = 1; cycle(); reset = 0;
    peek("rst2_kdata", A_KD, 32'h0);
    peek("rst2_sdata", A_SD, 32'h0);
    peek("rst2_kctrl", A_KC, 32'h0);
    peek("rst2_sctrl", A_SC, 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    abus = A_SD;
    run(7);
    peek("lat_early", A_SD, 32'h0);
    cycle();
    peek("lat_done", A_SD, 32'h155);
    peek("lat_ready", A_SC, 32'h1);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(9) == 0)  SW  = 10'($urandom);
      if ($urandom_range(11) == 0) KEY = 4'($urandom);
      case ($urandom_range(5))
        0: abus = A_KD;
        1: abus = A_SD;
        2: abus = A_KC;
        3: abus = A_SC;
        4: abus = A_NONE;
        default: abus = $urandom;
      endcase
      re    = ($urandom_range(2) == 0);
      we    = ($urandom_range(3) == 0);
      wdata = $urandom;
      reset = ($urandom_range(149) == 0);
      cycle();
    end
    reset = 0; re = 0; we = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kbsw_io_device.md
Name: kbsw_io_device

Overview:
- Memory-mapped responder for the processor's KEY and SW inputs. It answers the processor's data-bus loads and stores at ADDR_KEY/ADDR_SW and at two matching control registers.
- Each input bus goes through a synchronizer and a tick-sampled debouncer. A change in the debounced value sets a sticky Ready flag, with Overrun detection and an interrupt request.
- Sits beside data memory. The top level muxes rdata in when hit is high.

Parameters:
DBITS, 32, bus data/address width
ADDR_KDATA, 32'hF0000010, key data register
ADDR_SDATA, 32'hF0000014, switch data register
ADDR_KCTRL, 32'hF0000110, key control/status register
ADDR_SCTRL, 32'hF0000114, switch control/status register
DEBOUNCE_CYCLES, 100000, clocks between debounce samples (must be ≥2)
CNT_BITS, 17, width of the tick prescaler (must hold DEBOUNCE_CYCLES-1)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
KEY  in  4  raw board keys, active-low, asynchronous
SW  in  10  raw board switches, active-high, asynchronous
abus  in  DBITS  bus address from the processor
wdata  in  DBITS  store data
we  in  1  store strobe for this cycle
re  in  1  load strobe for this cycle
rdata  out  DBITS  load data; combinational from abus and registered state
hit  out  1  abus matches one of the four registers (re or we not required)
irq  out  1  (kready&kie)|(sready&sie), registered

Behaviour:
- Reset (on clk edge with reset=1):
  - Clears both synchronizer stages, sample registers, debounced values, prescaler, ready/overrun/ie bits and irq.
  - Debounced KEY reset value is 0 (no key pressed); debounced SW reset value is 0.
- Synchronizer:
  - Two flops per bit.
  - KEY is inverted before the first flop, so 1 means pressed.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick=1 in the cycle the count equals DEBOUNCE_CYCLES-1.
- Debounce, on a tick, per bus:
  - samp <= sync.
  - If sync==samp (stable across two ticks), deb <= sync.
  - A change event fires when deb is about to be updated to a value different from its current one.
  - Worst-case latency from raw edge to deb is 2 sync cycles plus 2*DEBOUNCE_CYCLES.
  - A glitch shorter than one tick period never reaches deb.
- Register map (32-bit):
  - KDATA: rdata = {28'b0, kdeb}. A store is ignored.
  - SDATA: rdata = {22'b0, sdeb}. A store is ignored.
  - KCTRL and SCTRL: bit0 ready (RO), bit2 overrun (write-0-to-clear), bit4 ie (RW). All other bits read 0.
  - A store writes bit4 (ie). It clears overrun if wdata[2]==0; wdata[2]=1 leaves overrun unchanged. wdata[0] is ignored.
  - Unmapped abus: hit=0, rdata=0, no side effects.
- Read side effect: re=1 at the DATA address clears that bus's ready at the clock edge. CTRL reads have no side effect.
- Ready/overrun update per bus, priority highest first:
  - change event and ready==1 and no DATA read this cycle: overrun<=1, ready stays 1.
  - change event (any other case): ready<=1. This includes a simultaneous DATA read, where set wins over clear and overrun does not set.
  - DATA read: ready<=0.
- Overrun set and a CTRL store clearing it in the same cycle: overrun ends at 1 (set wins).
- re and we both high in one cycle: the store applies and the read side effect also applies.
- irq is updated every edge from next-state values. It is therefore high in the same cycle that ready rises, when ie=1.
- Reset mid-debounce discards any partial sample.
- SW held nonzero across reset produces a normal change event after about 2 ticks.

Test Plan:
(All with DEBOUNCE_CYCLES=4.)
1. Reset, no input activity, read each of the 4 addresses -> rdata=0 everywhere; hit=1 for each; irq=0; abus=32'hF0000018 gives hit=0, rdata=0.
2. SW set to 10'h2A5 and held -> within 2+8 cycles SDATA reads 32'h2A5 and SCTRL reads 32'h1. One SDATA read -> SCTRL then reads 32'h0.
3. KEY[1] pulled low for 2 cycles, then back high -> KDATA stays 0 and KCTRL ready stays 0. Held low for 12 cycles -> KDATA reads 32'h2.
4. Two SW changes with no SDATA read in between -> SCTRL reads 32'h5. Store 32'h0 to SCTRL -> reads 32'h1. Store 32'h4 -> reads 32'h1 (overrun not re-set by the write).
5. Store 32'h10 to KCTRL, then press KEY[0] -> irq=1 in the same cycle ready rises. KDATA read -> irq=0 on the next cycle. Force the change event and the KDATA read into the same cycle -> ready stays 1, overrun stays 0.
6. Assert reset for 1 cycle while a switch change is half-debounced -> all registers read 0. Then a new change is detected only after the full latency.
